// File: rtl/inv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inv_pkg
// Description : Shared types and default widths for the inventory
//               read-modify-write engine.
// Revision    : 1.0 - initial release
// ============================================================================
package inv_pkg;

    // Default widths: item code (memory address) and stock count
    localparam int INV_ADDR_W = 8;
    localparam int INV_DATA_W = 8;

    // Request operation encoding as seen on req_op
    typedef enum logic [1:0] {
        OP_QUERY  = 2'b00,
        OP_ADD    = 2'b01,
        OP_REMOVE = 2'b10,
        OP_CLEAR  = 2'b11
    } op_t;

    // Response status encoding as seen on rsp_status
    typedef enum logic [1:0] {
        ST_OK    = 2'b00,
        ST_SAT   = 2'b01,
        ST_UNDER = 2'b10
    } status_t;

    // Engine sequencing: one request walks IDLE -> READ -> CALC -> WRITE
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READ  = 2'b01,
        S_CALC  = 2'b10,
        S_WRITE = 2'b11
    } state_t;

endpackage : inv_pkg
`default_nettype wire

// File: rtl/inv_sat_alu.sv
`default_nettype none
// ============================================================================
// Module      : inv_sat_alu
// Description : Combinational stock update. Saturating add, floor-checked
//               remove, clear and query, with status and write-enable.
//               INV_RMW_STRICT_EN : when defined, an underflowing remove
//               keeps the old count and suppresses the write; otherwise it
//               clamps the count to zero and writes it.
// Revision    : 1.0 - initial release
// ============================================================================
module inv_sat_alu
    import inv_pkg::*;
#(
    parameter int DATA_W = INV_DATA_W
) (
    input  op_t               i_op,
    input  logic [DATA_W-1:0] i_old,
    input  logic [DATA_W-1:0] i_quant,
    output logic [DATA_W-1:0] o_new,
    output status_t           o_status,
    output logic              o_wr_en
);

    // One extra bit so an add overflow is visible as the carry
    logic [DATA_W:0] w_sum;
    assign w_sum = {1'b0, i_old} + {1'b0, i_quant};

    // Select the new count, its status and whether it must be written back
    always_comb begin
        o_new    = i_old;
        o_status = ST_OK;
        o_wr_en  = 1'b1;
        case (i_op)
            OP_QUERY: begin
                o_wr_en = 1'b0;
            end
            OP_ADD: begin
                if (w_sum[DATA_W]) begin
                    o_new    = '1;
                    o_status = ST_SAT;
                end else begin
                    o_new = w_sum[DATA_W-1:0];
                end
            end
            OP_REMOVE: begin
                if (i_quant > i_old) begin
                    o_status = ST_UNDER;
`ifdef INV_RMW_STRICT_EN
                    // Leave the stored count alone and report it unchanged
                    o_new    = i_old;
                    o_wr_en  = 1'b0;
`else
                    // Clamp at empty and store that
                    o_new    = '0;
`endif
                end else begin
                    o_new = i_old - i_quant;
                end
            end
            OP_CLEAR: begin
                o_new = '0;
            end
            default: begin
                o_new = i_old;
            end
        endcase
    end

endmodule : inv_sat_alu
`default_nettype wire

// File: rtl/inventory_rmw.sv
`default_nettype none
// ============================================================================
// Module      : inventory_rmw
// Description : Read-modify-write engine owning the inventory memory port.
//               Accepts one stock request, reads the count, updates it via
//               inv_sat_alu, writes it back and returns the new count.
//               Four cycles per request; all outputs registered.
//               INV_RMW_STRICT_EN : selects strict (no-write) handling of an
//               underflowing remove instead of clamping to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module inventory_rmw
    import inv_pkg::*;
#(
    parameter int ADDR_W = INV_ADDR_W,
    parameter int DATA_W = INV_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_code,
    input  logic [DATA_W-1:0] req_quant,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_qty,
    output logic [1:0]        rsp_status,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata
);

    state_t            r_state;
    op_t               r_op;
    logic [DATA_W-1:0] r_quant;

    logic [DATA_W-1:0] w_new;
    status_t           w_status;
    logic              w_we;

    // Read data feeds the ALU directly; its result is registered in CALC
    inv_sat_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_op     (r_op),
        .i_old    (mem_rdata),
        .i_quant  (r_quant),
        .o_new    (w_new),
        .o_status (w_status),
        .o_wr_en  (w_we)
    );

    // Request sequencing with registered memory and response outputs.
    // mem_addr doubles as the latched item code for the whole request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_op       <= OP_QUERY;
            r_quant    <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_qty    <= '0;
            rsp_status <= ST_OK;
            mem_addr   <= '0;
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op      <= op_t'(req_op);
                        r_quant   <= req_quant;
                        mem_addr  <= req_code;
                        mem_rd_en <= 1'b1;
                        req_ready <= 1'b0;
                        r_state   <= S_READ;
                    end
                end
                S_READ: begin
                    mem_rd_en <= 1'b0;
                    r_state   <= S_CALC;
                end
                S_CALC: begin
                    mem_wr_en  <= w_we;
                    mem_wdata  <= w_new;
                    rsp_valid  <= 1'b1;
                    rsp_qty    <= w_new;
                    rsp_status <= w_status;
                    r_state    <= S_WRITE;
                end
                S_WRITE: begin
                    mem_wr_en <= 1'b0;
                    rsp_valid <= 1'b0;
                    mem_addr  <= '0;
                    req_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule : inventory_rmw
`default_nettype wire

// File: doc/inventory_rmw.md
# inventory_rmw

Read-modify-write engine between the inventory front-end and the inventory memory. It accepts one stock request at a time: item code, quantity and operation. It reads the stored count, applies saturating add/remove, clear or query, writes the result back, and returns the new count plus a status code. It owns the memory port, so the front-end never drives memory directly.

## Interface
- `ADDR_W`, default 8: item code width, which is the memory address.
- `DATA_W`, default 8: stock count width.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  engine idle; a request is accepted when `req_valid && req_ready` at a rising edge.
- `req_op`  in  2  operation: 00 query, 01 add, 10 remove, 11 clear.
- `req_code`  in  `ADDR_W`  item code.
- `req_quant`  in  `DATA_W`  quantity (ignored for query and clear).
- `rsp_valid`  out  1  one-cycle pulse: response fields valid.
- `rsp_qty`  out  `DATA_W`  count held in memory after the operation.
- `rsp_status`  out  2  response status: 00 OK, 01 SATURATED, 10 UNDERFLOW.
- `mem_addr`  out  `ADDR_W`  memory address.
- `mem_rd_en`  out  1  read strobe; `mem_rdata` is valid the following cycle.
- `mem_rdata`  in  `DATA_W`  read data.
- `mem_wr_en`  out  1  write strobe.
- `mem_wdata`  out  `DATA_W`  write data.

## Operation
- FSM states: IDLE, READ, CALC, WRITE.
- IDLE: `req_ready`=1. On accept, latch op, code and quant, then go to READ.
- READ: `mem_rd_en`=1 and `mem_addr`=latched code, then go to CALC.
- CALC: capture `mem_rdata` as `old`, compute `new` and status into registers, then go to WRITE.
- WRITE: `mem_wr_en`=1 except for query. `mem_wdata`=`new`, `rsp_valid`=1, `rsp_qty`=`new`. Then go to IDLE.
- Add: compute a `DATA_W`+1-bit sum.
  - Sum above 2^`DATA_W`-1: `new` = all ones, status SATURATED.
  - Otherwise: `new` = sum, status OK.
- Remove with quant ≤ old: `new` = old − quant, status OK.
- Remove with quant > old: status UNDERFLOW; the result depends on `INV_RMW_STRICT_EN` (see Configuration).
- Clear: `new` = 0, status OK.
- Query: `new` = old, no write, status OK.
- Quant 0 is legal for add and remove: `new` = old, status OK, the write is still issued.
- `mem_addr` holds the latched code in READ, CALC and WRITE. It is 0 in IDLE.
- Requests are never dropped. `req_valid` held while busy is accepted on the first IDLE cycle.

## Timing
- Accept edge T. `mem_rd_en` is high in cycle T+1. The compute is registered at the end of T+2. `mem_wr_en` and `rsp_valid` are high in cycle T+3.
- `req_ready` returns high at T+4. Throughput is one request per 4 cycles.
- Back-to-back requests to the same code are hazard-free: the write at T+3 precedes the next read at T+5 or later.
- All outputs are registered.
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_qty`=0, `rsp_status`=00, `mem_addr`=0, `mem_rd_en`=0, `mem_wr_en`=0, `mem_wdata`=0.
- Reset asserted mid-operation: immediate return to IDLE.
  - No write is issued and no response is produced.
  - Memory contents are untouched.
  - The in-flight request is lost; the front-end re-submits it.
- `rsp_valid` has no backpressure. The consumer must sample it in its pulse cycle.

## Configuration
- `INV_RMW_STRICT_EN` defined: remove with quant > old issues no write. `rsp_qty` = old, status UNDERFLOW.
- `INV_RMW_STRICT_EN` undefined: remove with quant > old clamps. Writes `new` = 0, `rsp_qty` = 0, status UNDERFLOW.
- All other behaviour is identical in both builds.

## Structure
- Package `inv_pkg` holds:
  - `op_t` enum: `OP_QUERY`, `OP_ADD`, `OP_REMOVE`, `OP_CLEAR`.
  - `status_t` enum: `ST_OK`, `ST_SAT`, `ST_UNDER`.
  - `state_t` enum.
  - Default width constants `INV_ADDR_W` and `INV_DATA_W`.
- One combinational sub-module, `inv_sat_alu`: inputs op, old and quant; outputs new, status and write-enable. It contains the strict/clamp `ifdef`.
- The top holds the FSM, the request latch and the memory/response registers.
- The bench models memory as a 2^`ADDR_W` array with a 1-cycle read.

## Test plan
- Reset, then add code 0x05, quant 10, memory at 0 → write 10 at T+3; `rsp_qty`=10, status OK; `req_ready` high at T+4.
- Memory[0x05]=250, add 10 → write 255, status SATURATED.
- Memory[0x05]=3, remove 7:
  - Strict build: no `mem_wr_en`, `rsp_qty`=3, UNDERFLOW.
  - Default build: write 0, `rsp_qty`=0, UNDERFLOW.
- Query code 0x05 holding 42 → `rsp_qty`=42, status OK, `mem_wr_en` never asserted. Clear code 0x05 → write 0, status OK.
- `req_valid` held high with two requests to the same code (add 5, then remove 2, from 0) → second accepted at T+4; final memory 3, responses 5 then 3.
- `rst_n` low during CALC → all outputs at reset values, no write observed, `req_ready`=1 after release.
